// File: rtl/gl2_stream_pkg.sv
// gl2_stream_pkg
//   Shared types for the gl2 stream join path.
//   - lane_sel_t : which upstream lane the join currently accepts from
//   - NUM_LANES  : number of lanes merged by the join
//   - next_lane  : round-robin successor of a lane, A->B->C->D->A
package gl2_stream_pkg;

  localparam int unsigned NUM_LANES = 4;

  typedef enum logic [1:0] {
    SEL_A = 2'd0,
    SEL_B = 2'd1,
    SEL_C = 2'd2,
    SEL_D = 2'd3
  } lane_sel_t;

  function automatic lane_sel_t next_lane(input lane_sel_t cur);
    lane_sel_t nxt;
    unique case (cur)
      SEL_A:   nxt = SEL_B;
      SEL_B:   nxt = SEL_C;
      SEL_C:   nxt = SEL_D;
      SEL_D:   nxt = SEL_A;
      default: nxt = SEL_A;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/gl2_stream_reg.sv
// gl2_stream_reg
//   Single-stage valid/ready pipeline register. Accepts a new beat whenever
//   the stage is empty or its current beat is being taken in the same cycle,
//   so back-to-back beats flow at one per clock with no bubble.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   in_data_i      upstream payload (WIDTH bits)
//   in_valid_i     upstream valid
//   in_ready_o     stage can load this cycle (combinational from state and out_ready_i)
//   out_data_o     registered payload
//   out_valid_o    registered valid
//   out_ready_i    downstream ready
module gl2_stream_reg #(
  parameter int unsigned WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             load_en;

  assign load_en = !valid_q || out_ready_i;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (load_en) begin
      // An empty slot with no new beat drops valid; payload is left as-is.
      valid_d = in_valid_i;
      if (in_valid_i) begin
        data_d = in_data_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign in_ready_o  = load_en;
  assign out_data_o  = data_q;
  assign out_valid_o = valid_q;

endmodule

// File: rtl/gl2_stream_join.sv
// gl2_stream_join
//   Four-to-one stream join. Takes one beat from each of lanes a, b, c, d in
//   that fixed order and serializes them onto one registered output stream.
//   A lane that is not selected is stalled even when valid; a missing lane
//   stalls the join indefinitely. tlast/tuser travel with their own beat.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   up_data_x/valid_x/tlast_x/tuser_x   lane x inputs (x = a..d)
//   up_ready_x                    lane x ready (only the selected lane)
//   down_data/valid/tlast/tuser   registered output stream
//   down_ready                    downstream ready
//   err_mismatch                  sticky group tlast/tuser inconsistency
// Configuration:
//   GL2_JOIN_CHECK_EN  when defined, builds the group-consistency checker that
//                      drives err_mismatch; otherwise err_mismatch is 0.
module gl2_stream_join
  import gl2_stream_pkg::*;
#(
  parameter int unsigned D_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [D_WIDTH-1:0] up_data_a,
  input  logic [D_WIDTH-1:0] up_data_b,
  input  logic [D_WIDTH-1:0] up_data_c,
  input  logic [D_WIDTH-1:0] up_data_d,
  input  logic               up_valid_a,
  input  logic               up_valid_b,
  input  logic               up_valid_c,
  input  logic               up_valid_d,
  input  logic               up_tlast_a,
  input  logic               up_tlast_b,
  input  logic               up_tlast_c,
  input  logic               up_tlast_d,
  input  logic               up_tuser_a,
  input  logic               up_tuser_b,
  input  logic               up_tuser_c,
  input  logic               up_tuser_d,
  output logic               up_ready_a,
  output logic               up_ready_b,
  output logic               up_ready_c,
  output logic               up_ready_d,
  output logic [D_WIDTH-1:0] down_data,
  output logic               down_valid,
  output logic               down_tlast,
  output logic               down_tuser,
  input  logic               down_ready,
  output logic               err_mismatch
);

  localparam int unsigned P_WIDTH = D_WIDTH + 2;

  lane_sel_t          state_q, state_d;
  logic               sel_valid;
  logic               sel_tlast;
  logic               sel_tuser;
  logic [D_WIDTH-1:0] sel_data;
  logic               load_en;
  logic               grant;
  logic               xfer;
  logic [P_WIDTH-1:0] reg_out;

  // Lane mux: payload and valid of the currently selected lane.
  always_comb begin
    sel_valid = 1'b0;
    sel_tlast = 1'b0;
    sel_tuser = 1'b0;
    sel_data  = '0;
    unique case (state_q)
      SEL_A: begin
        sel_valid = up_valid_a;
        sel_tlast = up_tlast_a;
        sel_tuser = up_tuser_a;
        sel_data  = up_data_a;
      end
      SEL_B: begin
        sel_valid = up_valid_b;
        sel_tlast = up_tlast_b;
        sel_tuser = up_tuser_b;
        sel_data  = up_data_b;
      end
      SEL_C: begin
        sel_valid = up_valid_c;
        sel_tlast = up_tlast_c;
        sel_tuser = up_tuser_c;
        sel_data  = up_data_c;
      end
      SEL_D: begin
        sel_valid = up_valid_d;
        sel_tlast = up_tlast_d;
        sel_tuser = up_tuser_d;
        sel_data  = up_data_d;
      end
      default: ;
    endcase
  end

  // The output register reports it can load whenever it is empty or draining.
  // Ready is additionally masked by rst so no lane sees a handshake in the
  // reset cycle, even though the register is empty then.
  assign grant = load_en && !rst;
  assign xfer  = sel_valid && grant;

  assign up_ready_a = grant && (state_q == SEL_A);
  assign up_ready_b = grant && (state_q == SEL_B);
  assign up_ready_c = grant && (state_q == SEL_C);
  assign up_ready_d = grant && (state_q == SEL_D);

  // Lane-select FSM: advances only on a transfer on the selected lane.
  always_comb begin
    state_d = state_q;
    if (xfer) begin
      state_d = next_lane(state_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SEL_A;
    end else begin
      state_q <= state_d;
    end
  end

  gl2_stream_reg #(
    .WIDTH (P_WIDTH)
  ) u_out_reg (
    .clk         (clk),
    .rst         (rst),
    .in_data_i   ({sel_tlast, sel_tuser, sel_data}),
    .in_valid_i  (sel_valid),
    .in_ready_o  (load_en),
    .out_data_o  (reg_out),
    .out_valid_o (down_valid),
    .out_ready_i (down_ready)
  );

  assign down_tlast = reg_out[P_WIDTH-1];
  assign down_tuser = reg_out[P_WIDTH-2];
  assign down_data  = reg_out[D_WIDTH-1:0];

`ifdef GL2_JOIN_CHECK_EN
  // Group-consistency checker: the lane-a beat sets the reference flags,
  // the b/c/d beats of the same group must match them.
  logic ref_tlast_q, ref_tlast_d;
  logic ref_tuser_q, ref_tuser_d;
  logic err_q, err_d;

  always_comb begin
    ref_tlast_d = ref_tlast_q;
    ref_tuser_d = ref_tuser_q;
    err_d       = err_q;
    if (xfer) begin
      if (state_q == SEL_A) begin
        ref_tlast_d = sel_tlast;
        ref_tuser_d = sel_tuser;
      end else if ((sel_tlast != ref_tlast_q) || (sel_tuser != ref_tuser_q)) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ref_tlast_q <= 1'b0;
      ref_tuser_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      ref_tlast_q <= ref_tlast_d;
      ref_tuser_q <= ref_tuser_d;
      err_q       <= err_d;
    end
  end

  assign err_mismatch = err_q;
`else
  assign err_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_gl2_stream_join.sv
module tb_gl2_stream_join;

  localparam int NG = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] uv, ul, uu, ur;
  logic [7:0] ud [4];
  logic [7:0] dd;
  logic       dv, dl, du, dr, err;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] ld [4][NG];
  logic       lt [4][NG];
  logic       lu [4][NG];
  logic [9:0] expv [4*NG];

  always #5 clk = ~clk;

  gl2_stream_join #(.D_WIDTH(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .up_data_a    (ud[0]),
    .up_data_b    (ud[1]),
    .up_data_c    (ud[2]),
    .up_data_d    (ud[3]),
    .up_valid_a   (uv[0]),
    .up_valid_b   (uv[1]),
    .up_valid_c   (uv[2]),
    .up_valid_d   (uv[3]),
    .up_tlast_a   (ul[0]),
    .up_tlast_b   (ul[1]),
    .up_tlast_c   (ul[2]),
    .up_tlast_d   (ul[3]),
    .up_tuser_a   (uu[0]),
    .up_tuser_b   (uu[1]),
    .up_tuser_c   (uu[2]),
    .up_tuser_d   (uu[3]),
    .up_ready_a   (ur[0]),
    .up_ready_b   (ur[1]),
    .up_ready_c   (ur[2]),
    .up_ready_d   (ur[3]),
    .down_data    (dd),
    .down_valid   (dv),
    .down_tlast   (dl),
    .down_tuser   (du),
    .down_ready   (dr),
    .err_mismatch (err)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    if (obs !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, want);
    end
  endtask

  task automatic set_lanes(input logic [3:0] v, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input logic [7:0] d);
    uv = v;
    ud[0] = a; ud[1] = b; ud[2] = c; ud[3] = d;
    ul = '0;
    uu = '0;
  endtask

  // Reset for one clock, checking ready is withheld and outputs clear.
  task automatic do_reset();
    rst = 1'b1;
    uv  = '0;
    dr  = 1'b1;
    @(negedge clk);
    check_eq("rst_rdy", ur, 4'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("rst_vld", dv, 1'b0);
    check_eq("rst_beat", {dl, du, dd}, 10'h000);
    check_eq("rst_err", err, 1'b0);
  endtask

  // One directed cycle: check readies/output, then drop valid on any lane
  // that transferred (each source offers exactly one beat).
  task automatic cyc(input string tag, input logic [3:0] eur, input logic edv, input logic [9:0] ebeat);
    logic [3:0] x;
    @(negedge clk);
    check_eq({tag, "_rdy"}, ur, eur);
    check_eq({tag, "_vld"}, dv, edv);
    if (edv) check_eq({tag, "_beat"}, {dl, du, dd}, ebeat);
    x = uv & ur;
    @(posedge clk);
    #1;
    uv = uv & ~x;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int idx [4];
    int nxt, oidx, cycles, cnt;
    logic stall_prev;
    logic [9:0] prev_beat;
    logic exp_err;

    uv = '0; ul = '0; uu = '0; dr = 1'b1;
    for (int x = 0; x < 4; x++) ud[x] = '0;
    @(posedge clk);
    #1;

    // T1: full group, no gaps; tuser only on a, tlast only on d.
    do_reset();
    set_lanes(4'hF, 8'h11, 8'h22, 8'h33, 8'h44);
    uu = 4'b0001;
    ul = 4'b1000;
    cyc("t1_c0", 4'b0001, 1'b0, 10'h000);
    cyc("t1_c1", 4'b0010, 1'b1, 10'h111);
    cyc("t1_c2", 4'b0100, 1'b1, 10'h022);
    cyc("t1_c3", 4'b1000, 1'b1, 10'h033);
    cyc("t1_c4", 4'b0001, 1'b1, 10'h244);
    cyc("t1_c5", 4'b0001, 1'b0, 10'h000);
`ifdef GL2_JOIN_CHECK_EN
    check_eq("t1_err", err, 1'b1);
`else
    check_eq("t1_err", err, 1'b0);
`endif

    // T2: lane c withheld for five cycles.
    do_reset();
    set_lanes(4'b1011, 8'h11, 8'h22, 8'h33, 8'h44);
    cyc("t2_c0", 4'b0001, 1'b0, 10'h000);
    cyc("t2_c1", 4'b0010, 1'b1, 10'h011);
    cyc("t2_c2", 4'b0100, 1'b1, 10'h022);
    for (int i = 3; i <= 6; i++) cyc("t2_hold", 4'b0100, 1'b0, 10'h000);
    uv[2] = 1'b1;
    cyc("t2_c7", 4'b0100, 1'b0, 10'h000);
    cyc("t2_c8", 4'b1000, 1'b1, 10'h033);
    cyc("t2_c9", 4'b0001, 1'b1, 10'h044);
    cyc("t2_c10", 4'b0001, 1'b0, 10'h000);

    // T3: reset after the b transfer, then a fresh group.
    do_reset();
    set_lanes(4'hF, 8'h11, 8'h22, 8'h33, 8'h44);
    cyc("t3_c0", 4'b0001, 1'b0, 10'h000);
    cyc("t3_c1", 4'b0010, 1'b1, 10'h011);
    rst = 1'b1;
    set_lanes(4'hF, 8'h55, 8'h66, 8'h77, 8'h88);
    @(negedge clk);
    check_eq("t3_rst_rdy", ur, 4'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc("t3_c3", 4'b0001, 1'b0, 10'h000);
    cyc("t3_c4", 4'b0010, 1'b1, 10'h055);
    cyc("t3_c5", 4'b0100, 1'b1, 10'h066);

    // Random phase: per-lane beat lists, expected output is the round-robin
    // interleave a0 b0 c0 d0 a1 ...
    exp_err = 1'b0;
    for (int g = 0; g < NG; g++) begin
      logic fl, fu;
      fl = 1'($urandom_range(0, 1));
      fu = 1'($urandom_range(0, 1));
      for (int x = 0; x < 4; x++) begin
        ld[x][g] = 8'($urandom);
        lt[x][g] = ($urandom_range(0, 7) == 0) ? !fl : fl;
        lu[x][g] = ($urandom_range(0, 7) == 0) ? !fu : fu;
        expv[4*g + x] = {lt[x][g], lu[x][g], ld[x][g]};
        if (x > 0 && (lt[x][g] != lt[0][g] || lu[x][g] != lu[0][g])) exp_err = 1'b1;
      end
    end
`ifndef GL2_JOIN_CHECK_EN
    exp_err = 1'b0;
`endif

    do_reset();
    for (int x = 0; x < 4; x++) idx[x] = 0;
    nxt = 0;
    oidx = 0;
    stall_prev = 1'b0;
    prev_beat = '0;
    for (cycles = 0; cycles < 6000 && oidx < 4*NG; cycles++) begin
      for (int x = 0; x < 4; x++) begin
        if (idx[x] < NG && $urandom_range(0, 3) != 0) begin
          uv[x] = 1'b1;
          ud[x] = ld[x][idx[x]];
          ul[x] = lt[x][idx[x]];
          uu[x] = lu[x][idx[x]];
        end else begin
          uv[x] = 1'b0;
          ud[x] = 8'($urandom);
          ul[x] = 1'($urandom_range(0, 1));
          uu[x] = 1'($urandom_range(0, 1));
        end
      end
      dr = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      cnt = $countones(ur);
      check_eq("rnd_rdy_onehot", (cnt <= 1), 1'b1);
      if (dv && !dr) check_eq("rnd_stall_rdy", ur, 4'h0);
      if (stall_prev) check_eq("rnd_stall_hold", {dv, dl, du, dd}, {1'b1, prev_beat});
      for (int x = 0; x < 4; x++) begin
        if (uv[x] && ur[x]) begin
          check_eq("rnd_order", x, nxt);
          idx[x]++;
          nxt = (nxt + 1) % 4;
        end
      end
      if (dv && dr) begin
        if (oidx < 4*NG) check_eq("rnd_beat", {dl, du, dd}, expv[oidx]);
        else check_eq("rnd_extra_beat", oidx, 4*NG - 1);
        oidx++;
      end
      stall_prev = dv && !dr;
      prev_beat  = {dl, du, dd};
      @(posedge clk);
      #1;
    end
    check_eq("rnd_drained", oidx, 4*NG);
    check_eq("rnd_err", err, exp_err);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gl2_stream_join.md
Name: gl2_stream_join

Overview:
- Four-to-one stream join: collects one beat from each of four upstream lanes (a, b, c, d) and serializes them onto a single downstream stream, in fixed order a, b, c, d.
- Inverse of the four-way fan-out in the 2x2 downscaler stream path.
- Sits where the four per-quadrant pixel streams rejoin before the downscaler output / DMA writer.
- Output is registered for timing closure; all ports use the gl2 valid/ready/tlast/tuser stream protocol.

Parameters:
- D_WIDTH, 8, data width of every lane and of the output.

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- up_data_a / _b / _c / _d  in  D_WIDTH  lane data
- up_valid_a / _b / _c / _d  in  1  lane valid
- up_tlast_a / _b / _c / _d  in  1  lane end-of-line
- up_tuser_a / _b / _c / _d  in  1  lane start-of-frame
- up_ready_a / _b / _c / _d  out  1  lane ready
- down_data  out  D_WIDTH  serialized data
- down_valid  out  1  output valid
- down_tlast  out  1  output end-of-line
- down_tuser  out  1  output start-of-frame
- down_ready  in  1  downstream ready
- err_mismatch  out  1  sticky lane-consistency error; see Optional Feature

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- Lane-select FSM, 2-bit state SEL_A -> SEL_B -> SEL_C -> SEL_D -> SEL_A.
  - Reset state is SEL_A.
  - The state advances only on a transfer on the selected lane: up_valid_x & up_ready_x.
- Output register (down_data, down_valid, down_tlast, down_tuser):
  - load_en = !down_valid | down_ready.
  - Only the selected lane sees ready: up_ready_x = load_en & (state == SEL_x). All other lanes' up_ready = 0 (combinational from state and the output register).
  - On a selected-lane transfer: the register captures that lane's data/tlast/tuser and sets down_valid = 1.
  - When load_en = 1 and the selected lane is not valid, down_valid clears to 0.
- Latency: 1 cycle from the upstream transfer to down_valid.
- Throughput: 1 beat/cycle while down_ready is held high. Full throughput is required; there must be no bubble on back-to-back transfers.
- tlast and tuser pass through unchanged with their own beat. The block does not merge or regenerate them.
- Ordering: the output always carries a, b, c, d, a, ...
  - A lane that is not selected is stalled even if valid, regardless of the other lanes.
  - A missing lane stalls the join indefinitely; no timeout.
- Downstream stall: down_valid=1 & down_ready=0 holds down_* stable and forces all up_ready = 0.
- Simultaneous events: a downstream accept and a new upstream load in the same cycle is a legal replace. down_valid stays 1 and the data updates.
- Reset values:
  - down_valid = 0, down_tlast = 0, down_tuser = 0, down_data = 0, err_mismatch = 0.
  - FSM = SEL_A; every up_ready = 0 during the reset cycle.
- Reset mid-group: the partial group is discarded and the FSM returns to SEL_A. Upstream sources are reset in the same cycle.
- up_valid_x may deassert without a transfer. Once down_valid is asserted, the output holds until accepted.

Optional Feature:
- Macro: GL2_JOIN_CHECK_EN.
- With the macro: a group-consistency checker.
  - Latch tlast and tuser of the lane-a beat.
  - On each of the b, c, d beats, compare that beat's tlast/tuser against the latched values.
  - Any difference sets err_mismatch = 1. It is sticky until rst.
  - Data flow is unaffected.
- Without the macro: err_mismatch is tied 0 and no checker logic is generated.

Decomposition:
- Package gl2_stream_pkg:
  - lane_sel_t enum {SEL_A, SEL_B, SEL_C, SEL_D} (2-bit);
  - constant NUM_LANES = 4.
- Sub-module gl2_stream_reg: a single-stage valid/ready pipeline register with payload width D_WIDTH+2. The join instantiates it for its output register.
- The FSM and the lane mux stay in the top module.

Test Plan:
- Reset, then all lanes valid with a=0x11, b=0x22, c=0x33, d=0x44 and down_ready=1 -> down_data 0x11, 0x22, 0x33, 0x44 on consecutive cycles, first one cycle after the first transfer, with no gaps.
- Lane c withheld for 5 cycles, all other lanes valid -> output 0x11, 0x22, then down_valid=0 for 5 cycles; up_ready_d=0 throughout; output resumes 0x33, 0x44.
- down_ready toggled 1,0,0,1 during a group -> down_data stable while stalled, no beat lost or duplicated; up_ready_* all 0 while stalled.
- tuser=1 on a only, tlast=1 on d only -> down_tuser=1 only with 0x11, down_tlast=1 only with 0x44.
- rst asserted after the b transfer, then a fresh group sent -> down_valid=0 the next cycle, FSM restarts at SEL_A, and the next output beat is lane a's data.
- With GL2_JOIN_CHECK_EN: tlast a=0, c=1 -> err_mismatch=1 after c's transfer and stays 1 until rst. Without the macro, err_mismatch remains 0.
